edge_row_packer: RTL

Packs a thresholded 1-bit edge-pixel stream into full-width bitmap rows and writes one row per BRAM word. Its output is the edge bitmap that the contour tracer scans row by row, with bit index equal to pixel column. It sits between the edge-detect pipeline and the edge-bitmap BRAM. It owns the BRAM write port and hands each finished frame to the tracer with a ready/ack handshake.

---
 rtl/edge_bitmap_pkg.sv | 26 ++
 rtl/edge_row_packer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/edge_bitmap_pkg.sv
// Shared definitions for the edge-bitmap path: geometry defaults, packer state
// encoding and the frame ready/ack handshake seen by the contour tracer.
package edge_bitmap_pkg;

   localparam int ROW_BITS_DEF   = 1024;
   localparam int ADDR_W_DEF     = 10;
   localparam int FRAME_ROWS_DEF = 768;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_HOLD = 2'd2
   } pack_state_t;

   // Producer raises ready once the whole frame is in BRAM; the tracer's ack
   // only counts while ready is high, and releases the frame back to the packer.
   typedef struct packed {
      logic ready;
      logic ack;
   } frame_hs_t;

   function automatic logic hs_release(input frame_hs_t hs);
      return hs.ready & hs.ack;
   endfunction

endpackage

// File: rtl/edge_row_packer.sv
// Packs a 1-bit edge-pixel stream into ROW_BITS-wide bitmap rows, writes one
// row per BRAM word and holds each completed frame until the tracer acks it.
module edge_row_packer
   import edge_bitmap_pkg::*;
#(
   parameter int ROW_BITS   = ROW_BITS_DEF,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int FRAME_ROWS = FRAME_ROWS_DEF
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pix_valid,
   input  logic                pix_edge,
   input  logic                pix_sof,
   input  logic                frame_ack,
   output logic                bram_en,
   output logic                bram_we,
   output logic [ADDR_W-1:0]   bram_addr,
   output logic [ROW_BITS-1:0] bram_din,
   output logic                frame_ready,
   output logic                frame_abort,
   output logic                drop_err
);

   localparam int                COL_W    = (ROW_BITS > 1) ? $clog2(ROW_BITS) : 1;
   localparam logic [COL_W-1:0]  LAST_COL = COL_W'(ROW_BITS - 1);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(FRAME_ROWS - 1);

   pack_state_t         state;
   pack_state_t         state_nxt;
   logic [COL_W-1:0]    col;
   logic [ADDR_W-1:0]   row;
   logic [ROW_BITS-1:0] row_buf;

   logic                accept;
   logic                abort_now;
   logic                row_done;
   logic                frame_done;
   logic [COL_W-1:0]    acc_col;
   logic [ADDR_W-1:0]   acc_row;
   logic [ROW_BITS-1:0] merged_row;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // An SOF pixel always lands at (0,0); acc_col/acc_row give the position the
   // accepted pixel really occupies so the row-complete test sees SOF first.
   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      abort_now  = 1'b0;
      acc_col    = col;
      acc_row    = row;
      case (state)
         ST_IDLE: begin
            if (pix_valid && pix_sof) begin
               accept    = 1'b1;
               acc_col   = '0;
               acc_row   = '0;
               state_nxt = ST_FILL;
            end
         end
         ST_FILL: begin
            if (pix_valid) begin
               accept = 1'b1;
               if (pix_sof) begin
                  acc_col   = '0;
                  acc_row   = '0;
                  abort_now = (row != '0) || (col != '0);
               end
            end
         end
         ST_HOLD: begin
            if (hs_release(frame_hs_t'{ready: frame_ready, ack: frame_ack})) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      row_done   = accept && (acc_col == LAST_COL);
      frame_done = row_done && (acc_row == LAST_ROW);
      if (frame_done) begin
         state_nxt = ST_HOLD;
      end

      merged_row          = row_buf;
      merged_row[acc_col] = pix_edge;
   end

   // The output write register is loaded from merged_row, so column 0 of the
   // next row can overwrite row_buf in the very next cycle without a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         col         <= '0;
         row         <= '0;
         row_buf     <= '0;
         bram_din    <= '0;
         bram_addr   <= '0;
         bram_we     <= 1'b0;
         frame_ready <= 1'b0;
         frame_abort <= 1'b0;
         drop_err    <= 1'b0;
      end else begin
         bram_we     <= row_done;
         frame_abort <= abort_now;
         frame_ready <= (state == ST_HOLD) && (state_nxt == ST_HOLD);
         if ((state == ST_HOLD) && pix_valid) begin
            drop_err <= 1'b1;
         end
         if (accept) begin
            row_buf <= merged_row;
            if (row_done) begin
               bram_din  <= merged_row;
               bram_addr <= acc_row;
               col       <= '0;
               row       <= frame_done ? '0 : acc_row + ADDR_W'(1);
            end else begin
               col <= acc_col + COL_W'(1);
               row <= acc_row;
            end
         end
      end
   end

   assign bram_en = bram_we;

endmodule
